uart_rx_param: RTL and testbench

- Parametrised UART receiver; successor to the fixed 8-bit receiver.
- Adds a configurable data width, oversampling ratio, runtime baud divisor, parity, 1 or 2 stop bits, and error flags (framing, parity, overrun).
- Adds a valid/ready output handshake.
- Sits between the board RX pin and the command/byte consumer logic.
- Single clock domain: the baud tick is generated internally, so no divided clock is needed.

---
 rtl/uart_rx_param.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with runtime divisor, parity, 1/2 stop bits, error flags and valid/ready output.
// Optional: define RX_MAJORITY_EN to make every bit decision a 3-sample majority vote.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   input  logic [DIV_W-1:0]     divisor,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(DATA_BITS + 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_reg, state_next;
   logic [1:0]           sync_reg;
   logic                 rx_s, rx_prev_reg;
   logic [2:0]           settle_reg;
   logic [DIV_W-1:0]     div_cnt_reg, div_cnt_next, div_last;
   logic                 tick, start_edge, sample, par_en, complete;
   logic [OS_W-1:0]      os_cnt_reg, os_cnt_next;
   logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic                 stop2_reg, stop2_next;
   logic [DATA_BITS-1:0] shreg_reg, shreg_next, data_next;
   logic                 par_bad_reg, par_bad_next, fr_bad_reg, fr_bad_next;
   logic [1:0]           pmode_reg, pmode_next;
   logic                 two_stop_reg, two_stop_next;
   logic                 valid_next, perr_next, ferr_next, ovr_next;

   assign rx_s       = sync_reg[1];
   assign div_last   = (divisor == '0) ? '0 : divisor - 1'b1;
   assign tick       = (div_cnt_reg >= div_last);
   // rx_prev only holds a real line sample once the synchroniser has flushed its reset ones
   assign start_edge = settle_reg[2] & rx_prev_reg & ~rx_s;
   assign par_en     = (pmode_reg == 2'd1) || (pmode_reg == 2'd2);
   assign busy       = (state_reg != IDLE);

`ifdef RX_MAJORITY_EN
   logic [1:0] hist_reg;
   assign sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
   always_ff @(posedge clk) begin
      if (rst)       hist_reg <= 2'b11;
      else if (tick) hist_reg <= {hist_reg[0], rx_s};
   end
`else
   assign sample = rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
         settle_reg  <= '0;
      end else begin
         sync_reg    <= {sync_reg[0], rx_in};
         rx_prev_reg <= rx_s;
         settle_reg  <= {settle_reg[1:0], 1'b1};
      end
   end

   always_comb begin
      state_next    = state_reg;
      div_cnt_next  = tick ? '0 : div_cnt_reg + 1'b1;
      os_cnt_next   = os_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop2_next    = stop2_reg;
      shreg_next    = shreg_reg;
      par_bad_next  = par_bad_reg;
      fr_bad_next   = fr_bad_reg;
      pmode_next    = pmode_reg;
      two_stop_next = two_stop_reg;
      data_next     = data_out;
      valid_next    = data_valid;
      perr_next     = parity_err;
      ferr_next     = frame_err;
      ovr_next      = overrun_err;
      complete      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_edge) begin
               state_next    = START;
               div_cnt_next  = '0;
               os_cnt_next   = '0;
               bit_cnt_next  = '0;
               stop2_next    = 1'b0;
               par_bad_next  = 1'b0;
               fr_bad_next   = 1'b0;
               pmode_next    = parity_mode;
               two_stop_next = two_stop;
            end
         end
         START: begin
            if (tick) begin
               if (os_cnt_reg == OS_MID) begin
                  os_cnt_next  = '0;
                  bit_cnt_next = '0;
                  state_next   = sample ? IDLE : DATA;
               end else begin
                  os_cnt_next = os_cnt_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (os_cnt_reg == OS_LAST) begin
                  os_cnt_next  = '0;
                  shreg_next   = {sample, shreg_reg[DATA_BITS-1:1]};
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == BC_LAST) state_next = par_en ? PARITY : STOP;
               end else begin
                  os_cnt_next = os_cnt_reg + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               if (os_cnt_reg == OS_LAST) begin
                  os_cnt_next  = '0;
                  par_bad_next = (^shreg_reg ^ sample) != (pmode_reg == 2'd2);
                  state_next   = STOP;
               end else begin
                  os_cnt_next = os_cnt_reg + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (os_cnt_reg == OS_LAST) begin
                  os_cnt_next = '0;
                  fr_bad_next = fr_bad_reg | ~sample;
                  if (two_stop_reg && !stop2_reg) begin
                     stop2_next = 1'b1;
                  end else begin
                     complete   = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  os_cnt_next = os_cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // A completion takes priority over a plain accept; a blocked completion only flags overrun
      if (complete) begin
         if (!data_valid || data_ready) begin
            data_next  = shreg_reg;
            perr_next  = par_bad_reg;
            ferr_next  = fr_bad_next;
            valid_next = 1'b1;
            ovr_next   = 1'b0;
         end else begin
            ovr_next = 1'b1;
         end
      end else if (data_valid && data_ready) begin
         valid_next = 1'b0;
         perr_next  = 1'b0;
         ferr_next  = 1'b0;
         ovr_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         os_cnt_reg   <= '0;
         bit_cnt_reg  <= '0;
         stop2_reg    <= 1'b0;
         shreg_reg    <= '0;
         par_bad_reg  <= 1'b0;
         fr_bad_reg   <= 1'b0;
         pmode_reg    <= 2'd0;
         two_stop_reg <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         div_cnt_reg  <= div_cnt_next;
         os_cnt_reg   <= os_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop2_reg    <= stop2_next;
         shreg_reg    <= shreg_next;
         par_bad_reg  <= par_bad_next;
         fr_bad_reg   <= fr_bad_next;
         pmode_reg    <= pmode_next;
         two_stop_reg <= two_stop_next;
         data_out     <= data_next;
         data_valid   <= valid_next;
         parity_err   <= perr_next;
         frame_err    <= ferr_next;
         overrun_err  <= ovr_next;
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: vector table, hand-written corner sequences, random frames vs. a frame-level model.
module tb_uart_rx_param;
   localparam int DB = 8;
   localparam int OS = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst, rx_in, two_stop, data_ready;
   logic [DW-1:0] divisor;
   logic [1:0]    parity_mode;
   logic [DB-1:0] data_out;
   logic          data_valid, parity_err, frame_err, overrun_err, busy;

   always #5 clk = ~clk;

   uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .divisor(divisor),
      .parity_mode(parity_mode), .two_stop(two_stop),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
      .busy(busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drives one complete frame plus two idle bit times, one rx_in update per negedge.
   // Clocks [g_at, g_at+g_len) of the frame are inverted to model a line glitch.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                             input logic pflip, input logic [1:0] stops, input logic [15:0] div,
                             input int g_at, input int g_len);
      logic [15:0] fb;
      int          n;
      int          bitlen;
      bitlen = OS * ((div == 16'd0) ? 1 : int'(div));
      fb     = '1;
      fb[0]  = 1'b0;
      fb[8:1] = d;
      n = 9;
      if (pm == 2'd1 || pm == 2'd2) begin
         fb[n] = ((pm == 2'd2) ? ~^d : ^d) ^ pflip;
         n++;
      end
      fb[n] = stops[0];
      n++;
      if (ts) begin
         fb[n] = stops[1];
         n++;
      end
      n += 2;
      divisor     = div;
      parity_mode = pm;
      two_stop    = ts;
      for (int c = 0; c < n * bitlen; c++) begin
         rx_in = fb[c / bitlen] ^ ((c >= g_at) && (c < g_at + g_len));
         @(negedge clk);
      end
   endtask

   task automatic pulse_ready(input string name);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      check({name, "_accept_valid"}, 32'(data_valid), 32'd0);
      check({name, "_accept_ovr"},   32'(overrun_err), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  d;
      logic [1:0]  pm;
      logic        ts;
      logic        pflip;
      logic [1:0]  stops;
      logic [15:0] div;
      logic [7:0]  exp_d;
      logic        exp_pe;
      logic        exp_fe;
   } vec_t;

   vec_t vt[8];

   logic [7:0]  rd;
   logic [1:0]  rpm, rstops;
   logic        rts, rpf, f_pe, f_fe;
   logic [15:0] rdiv;
   logic        m_valid, m_pe, m_fe, m_ovr;
   logic [7:0]  m_d;

   initial begin
      vt[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 8'hA5, 1'b0, 1'b0};
      vt[1] = '{8'h3C, 2'd1, 1'b0, 1'b1, 2'b11, 16'd4, 8'h3C, 1'b1, 1'b0};
      vt[2] = '{8'h3C, 2'd1, 1'b0, 1'b0, 2'b11, 16'd4, 8'h3C, 1'b0, 1'b0};
      vt[3] = '{8'h96, 2'd0, 1'b1, 1'b0, 2'b01, 16'd4, 8'h96, 1'b0, 1'b1};
      vt[4] = '{8'h00, 2'd0, 1'b0, 1'b0, 2'b00, 16'd4, 8'h00, 1'b0, 1'b1};
      vt[5] = '{8'h5B, 2'd2, 1'b0, 1'b0, 2'b11, 16'd2, 8'h5B, 1'b0, 1'b0};
      vt[6] = '{8'hC3, 2'd3, 1'b0, 1'b1, 2'b11, 16'd0, 8'hC3, 1'b0, 1'b0};
      vt[7] = '{8'h7E, 2'd2, 1'b1, 1'b1, 2'b10, 16'd3, 8'h7E, 1'b1, 1'b1};

      // Reset with the line held low: no frame may start afterwards
      rst = 1'b1; rx_in = 1'b0; data_ready = 1'b0;
      divisor = 16'd4; parity_mode = 2'd0; two_stop = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_valid", 32'(data_valid), 32'd0);
      check("reset_data",  32'(data_out),   32'd0);
      check("reset_flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
      check("reset_busy",  32'(busy),       32'd0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("low_after_reset_busy",  32'(busy),       32'd0);
      check("low_after_reset_valid", 32'(data_valid), 32'd0);
      rx_in = 1'b1;
      repeat (100) @(negedge clk);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         send_frame(vt[i].d, vt[i].pm, vt[i].ts, vt[i].pflip, vt[i].stops, vt[i].div, 0, 0);
         $display("vec %0d data=%02h valid=%0b perr=%0b ferr=%0b ovr=%0b", i, data_out, data_valid,
                  parity_err, frame_err, overrun_err);
         check($sformatf("vec%0d_valid", i), 32'(data_valid), 32'd1);
         check($sformatf("vec%0d_data", i),  32'(data_out),   32'(vt[i].exp_d));
         check($sformatf("vec%0d_perr", i),  32'(parity_err), 32'(vt[i].exp_pe));
         check($sformatf("vec%0d_ferr", i),  32'(frame_err),  32'(vt[i].exp_fe));
         check($sformatf("vec%0d_ovr", i),   32'(overrun_err), 32'd0);
         check($sformatf("vec%0d_busy", i),  32'(busy),       32'd0);
         pulse_ready($sformatf("vec%0d", i));
         check($sformatf("vec%0d_flags_clr", i), {30'd0, parity_err, frame_err}, 32'd0);
      end

      // Start glitch of 20 clk (< half bit of 32 clk) is rejected
      divisor = 16'd4; parity_mode = 2'd0; two_stop = 1'b0;
      rx_in = 1'b0;
      repeat (20) @(negedge clk);
      rx_in = 1'b1;
      check("glitch_busy_high", 32'(busy), 32'd1);
      repeat (40) @(negedge clk);
      check("glitch_busy_low", 32'(busy), 32'd0);
      check("glitch_no_valid", 32'(data_valid), 32'd0);
      send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
      $display("glitch_then data=%02h valid=%0b", data_out, data_valid);
      check("glitch_next_valid", 32'(data_valid), 32'd1);
      check("glitch_next_data",  32'(data_out),   32'h5A);

      // Reset during data bit 4 of 0xFF, with 0x5A still held
      fork
         send_frame(8'hFF, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
         begin
            repeat (5 * 64 + 32) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_valid", 32'(data_valid), 32'd0);
            check("midrst_data",  32'(data_out),   32'd0);
            check("midrst_busy",  32'(busy),       32'd0);
         end
      join
      check("midrst_no_completion", 32'(data_valid), 32'd0);
      send_frame(8'h81, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
      $display("after_rst data=%02h valid=%0b", data_out, data_valid);
      check("after_rst_data", 32'(data_out), 32'h81);
      pulse_ready("after_rst");

      // One-tick glitch exactly over the centre sample of bit 3 (a 0) of 0x81
      send_frame(8'h81, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 286, 4);
      $display("centre_glitch data=%02h valid=%0b", data_out, data_valid);
`ifdef RX_MAJORITY_EN
      check("centre_glitch_data", 32'(data_out), 32'h81);
`else
      check("centre_glitch_data", 32'(data_out), 32'h89);
`endif
      pulse_ready("centre_glitch");

      // Overrun: hold data_ready low across two frames
      send_frame(8'h11, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
      send_frame(8'h22, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
      $display("overrun data=%02h valid=%0b ovr=%0b", data_out, data_valid, overrun_err);
      check("ovr_data",  32'(data_out),    32'h11);
      check("ovr_flag",  32'(overrun_err), 32'd1);
      check("ovr_valid", 32'(data_valid),  32'd1);
      pulse_ready("ovr");

      // Completion coinciding with data_ready: completion edge is posedge 3+152*div after the start bit
      send_frame(8'h11, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
      send_frame(8'h33, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
      check("coin_pre_ovr", 32'(overrun_err), 32'd1);
      fork
         send_frame(8'h22, 2'd0, 1'b0, 1'b0, 2'b11, 16'd4, 0, 0);
         begin
            repeat (3 + 152 * 4 - 1) @(posedge clk);
            @(negedge clk);
            data_ready = 1'b1;
            @(negedge clk);
            data_ready = 1'b0;
            $display("coincident data=%02h valid=%0b ovr=%0b", data_out, data_valid, overrun_err);
            check("coin_data",  32'(data_out),    32'h22);
            check("coin_valid", 32'(data_valid),  32'd1);
            check("coin_ovr",   32'(overrun_err), 32'd0);
         end
      join
      pulse_ready("coin");

      // Random frames against a frame-level model of the held word
      m_valid = 1'b0; m_d = 8'h00; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < 24; i++) begin
         rd     = 8'($urandom);
         rpm    = 2'($urandom_range(0, 3));
         rts    = 1'($urandom_range(0, 1));
         rpf    = 1'($urandom_range(0, 1));
         rstops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         rdiv   = 16'($urandom_range(0, 4));
         send_frame(rd, rpm, rts, rpf, rstops, rdiv, 0, 0);
         f_pe = ((rpm == 2'd1) || (rpm == 2'd2)) && rpf;
         f_fe = !rstops[0] || (rts && !rstops[1]);
         if (!m_valid) begin
            m_valid = 1'b1; m_d = rd; m_pe = f_pe; m_fe = f_fe; m_ovr = 1'b0;
         end else begin
            m_ovr = 1'b1;
         end
         $display("rand %0d sent=%02h pm=%0d ts=%0b div=%0d got=%02h perr=%0b ferr=%0b ovr=%0b",
                  i, rd, rpm, rts, rdiv, data_out, parity_err, frame_err, overrun_err);
         check($sformatf("rand%0d_valid", i), 32'(data_valid),  32'(m_valid));
         check($sformatf("rand%0d_data", i),  32'(data_out),    32'(m_d));
         check($sformatf("rand%0d_perr", i),  32'(parity_err),  32'(m_pe));
         check($sformatf("rand%0d_ferr", i),  32'(frame_err),   32'(m_fe));
         check($sformatf("rand%0d_ovr", i),   32'(overrun_err), 32'(m_ovr));
         if ($urandom_range(0, 3) != 0) begin
            pulse_ready($sformatf("rand%0d", i));
            m_valid = 1'b0; m_ovr = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
